x_lane_buffer: RTL and testbench

Parametrised operand buffer for the matrix-multiply datapath, feeding the MAC array.
- Accepts a serial stream of DATA_W-bit X elements over a valid/ready handshake.
- Distributes elements round-robin into LANES circular lanes of DEPTH elements each.
- Presents all lane heads in parallel; on each shift command, rotates every lane by one element so the operand set can be replayed for successive coefficient columns without reloading.

---
 rtl/x_lane_buffer.sv | 158 +++++++++++++++
 tb/tb_x_lane_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/x_lane_buffer.sv
// x_lane_buffer: operand buffer feeding the MAC array.
// A serial X stream is dealt round-robin into LANES circular lanes of DEPTH
// elements. Once full, all lane heads are presented in parallel, and each
// x_shift rotates every lane by one so the operand set can be replayed.
// Optional build macro: X_LANE_BUF_OVF_EN enables the sticky ovf_err flag.
module x_lane_buffer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      x_shift,
  output logic [LANES*DATA_W-1:0]   x_heads,
  output logic                      xload_done,
  output logic [$clog2(DEPTH)-1:0]  shift_idx,
  output logic                      pass_done,
  output logic                      ovf_err
);

  localparam int TOTAL = LANES * DEPTH;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int LP_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL - 1);
  localparam logic [LP_W-1:0]  LAST_LANE = LP_W'(LANES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [LP_W-1:0]   lane_ptr_reg, lane_ptr_next;
  logic [IDX_W-1:0]  shift_idx_reg, shift_idx_next;
  logic              pass_done_reg, pass_done_next;

  // clear outranks both loading and shifting, so it gates the fire strobes
  logic load_fire;
  logic shift_fire;
  assign load_fire  = (state_reg == S_LOAD) && in_valid && !clear;
  assign shift_fire = (state_reg == S_FULL) && x_shift && !clear;

  // Control registers: state, load counter, lane pointer, rotation position
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_LOAD;
      cnt_reg       <= '0;
      lane_ptr_reg  <= '0;
      shift_idx_reg <= '0;
      pass_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      lane_ptr_reg  <= lane_ptr_next;
      shift_idx_reg <= shift_idx_next;
      pass_done_reg <= pass_done_next;
    end
  end

  // Next-state logic: clear restarts, LOAD counts accepts, FULL counts shifts
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lane_ptr_next  = lane_ptr_reg;
    shift_idx_next = shift_idx_reg;
    pass_done_next = 1'b0;
    if (clear) begin
      state_next     = S_LOAD;
      cnt_next       = '0;
      lane_ptr_next  = '0;
      shift_idx_next = '0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          if (in_valid) begin
            // explicit wrap: LANES need not be a power of two
            lane_ptr_next = (lane_ptr_reg == LAST_LANE) ? '0 : lane_ptr_reg + 1'b1;
            if (cnt_reg == LAST_CNT) begin
              cnt_next   = '0;
              state_next = S_FULL;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (x_shift) begin
            if (shift_idx_reg == LAST_IDX) begin
              shift_idx_next = '0;
              pass_done_next = 1'b1;
            end else begin
              shift_idx_next = shift_idx_reg + 1'b1;
            end
          end
        end
        default: state_next = S_LOAD;
      endcase
    end
  end

  // Per-lane storage. Slot 0 is the head. Loading and rotating are the same
  // shift toward the head; only the value entering the tail differs
  // (new element while loading, the old head while rotating).
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] mem_reg [DEPTH];
      logic              lane_load;
      logic [DATA_W-1:0] tail_in;

      assign lane_load = load_fire && (lane_ptr_reg == LP_W'(gi));
      assign tail_in   = shift_fire ? mem_reg[0] : in_data;

      // Shift the lane on a load into this lane or on a rotation of all lanes
      always_ff @(posedge clk) begin
        if (!rst || clear) begin
          for (int k = 0; k < DEPTH; k++) mem_reg[k] <= '0;
        end else if (lane_load || shift_fire) begin
          for (int k = 0; k < DEPTH - 1; k++) mem_reg[k] <= mem_reg[k+1];
          mem_reg[DEPTH-1] <= tail_in;
        end
      end

      assign x_heads[gi*DATA_W +: DATA_W] = mem_reg[0];
    end
  endgenerate

`ifdef X_LANE_BUF_OVF_EN
  logic ovf_err_reg;

  // Sticky overflow: any offered element while full; only rst clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_err_reg <= 1'b0;
    end else if (in_valid && (state_reg == S_FULL) && !clear) begin
      ovf_err_reg <= 1'b1;
    end
  end

  assign ovf_err = ovf_err_reg;
`else
  assign ovf_err = 1'b0;
`endif

  assign in_ready   = (state_reg == S_LOAD);
  assign xload_done = (state_reg == S_FULL);
  assign shift_idx  = shift_idx_reg;
  assign pass_done  = pass_done_reg;

endmodule

// File: tb/tb_x_lane_buffer.sv
// Self-checking bench for x_lane_buffer with a scoreboard of expected heads.
// A reference model records which element went to which lane slot; expected
// head words are pushed when stimulus is driven and popped when observed.
module tb_x_lane_buffer;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int DEPTH  = 8;
  localparam int TOTAL  = LANES * DEPTH;
  localparam int HW     = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              x_shift;
  logic [HW-1:0]     x_heads;
  logic              xload_done;
  logic [$clog2(DEPTH)-1:0] shift_idx;
  logic              pass_done;
  logic              ovf_err;

  x_lane_buffer #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .x_shift    (x_shift),
    .x_heads    (x_heads),
    .xload_done (xload_done),
    .shift_idx  (shift_idx),
    .pass_done  (pass_done),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] mdl [LANES][DEPTH];
  int                mdl_cnt;
  logic [HW-1:0]     exp_q [$];
  logic              exp_ovf;

`ifdef X_LANE_BUF_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("[TB] ok %s = %h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected heads after r rotations, from the model's lane contents
  task automatic push_heads(input int r);
    logic [HW-1:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++) w[l*DATA_W +: DATA_W] = mdl[l][r % DEPTH];
    exp_q.push_back(w);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      chk(tag, 64'(x_heads), 64'(exp_q.pop_front()));
    end
  endtask

  // Stream TOTAL elements base+i; optional idle cycle between them
  task automatic load_stream(input logic [DATA_W-1:0] base, input bit gaps, input bit shift_on);
    mdl_cnt = 0;
    x_shift = shift_on;
    for (int i = 0; i < TOTAL; i++) begin
      in_valid = 1'b1;
      in_data  = base + DATA_W'(i);
      mdl[mdl_cnt % LANES][mdl_cnt / LANES] = in_data;
      mdl_cnt++;
      step();
      if (i == TOTAL - 2) chk("ready_before_last", 64'(in_ready), 64'd1);
      if (gaps) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
    x_shift  = 1'b0;
    push_heads(0);
    chk("ready_after_load", 64'(in_ready), 64'd0);
    chk("xload_done", 64'(xload_done), 64'd1);
    pop_check("heads_full");
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; x_shift = 1'b0;
    exp_ovf = 1'b0;
    step(); step();
    rst = 1'b1;
    chk("rst_heads", 64'(x_heads), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_done", 64'(xload_done), 64'd0);
    chk("rst_idx", 64'(shift_idx), 64'd0);
    chk("rst_pass", 64'(pass_done), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);

    // Continuous load with x_shift held high throughout (must be ignored)
    load_stream(8'h00, 1'b0, 1'b1);
    chk("heads_lit", 64'(x_heads), 64'h03020100);

    // Full rotation pass
    for (int r = 1; r <= DEPTH; r++) begin
      x_shift = 1'b1;
      push_heads(r);
      step();
      x_shift = 1'b0;
      pop_check($sformatf("heads_rot%0d", r));
      chk($sformatf("idx_rot%0d", r), 64'(shift_idx), 64'(r % DEPTH));
      chk($sformatf("pass_rot%0d", r), 64'(pass_done), 64'(r == DEPTH));
      if (r == 1) chk("heads_rot1_lit", 64'(x_heads), 64'h07060504);
      step();
      chk($sformatf("pass_idle%0d", r), 64'(pass_done), 64'd0);
    end
    chk("heads_wrap_lit", 64'(x_heads), 64'h03020100);

    // Overflow attempt while FULL
    in_valid = 1'b1; in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    exp_ovf = OVF_EN;
    chk("ovf_set", 64'(ovf_err), 64'(exp_ovf));
    chk("ovf_heads", 64'(x_heads), 64'h03020100);
    chk("ovf_ready", 64'(in_ready), 64'd0);

    // clear keeps ovf_err, empties storage
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_heads", 64'(x_heads), 64'd0);
    chk("clr_done", 64'(xload_done), 64'd0);
    chk("clr_ready", 64'(in_ready), 64'd1);
    chk("clr_ovf", 64'(ovf_err), 64'(exp_ovf));

    // Gapped load gives the same result
    load_stream(8'h00, 1'b1, 1'b0);
    chk("gap_heads_lit", 64'(x_heads), 64'h03020100);

    // One shift, then clear together with x_shift: clear wins
    x_shift = 1'b1;
    step();
    chk("pre_clr_idx", 64'(shift_idx), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0; x_shift = 1'b0;
    chk("clrshift_heads", 64'(x_heads), 64'd0);
    chk("clrshift_idx", 64'(shift_idx), 64'd0);

    // Partial load of 10, then clear with in_valid: element dropped
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'h80 + 8'(i);
      step();
    end
    clear = 1'b1; in_data = 8'h55;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("midclr_heads", 64'(x_heads), 64'd0);
    chk("midclr_ready", 64'(in_ready), 64'd1);
    load_stream(8'h00, 1'b0, 1'b0);
    chk("reload_heads_lit", 64'(x_heads), 64'h03020100);

    // Reset clears the sticky flag
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst2_ovf", 64'(ovf_err), 64'd0);
    chk("rst2_heads", 64'(x_heads), 64'd0);

    if (exp_q.size() != 0) chk("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
